branch_resolve_predict: RTL and testbench
=========================================

Name: branch_resolve_predict

Overview:
- Parametrised successor to the single-bit branch-enable decoder.
- Evaluates all six RV32I conditional-branch compares internally from raw rs1/rs2 operands and funct3.
- Holds a table of saturating direction counters, indexed by PC with optional gshare history. Predicts at fetch, trains at resolve.
- Flags mispredicts and keeps saturating branch/mispredict counters.
- Sits between the fetch PC mux (prediction) and execute (resolution).

Parameters:
XLEN, 32, operand and PC width
BHT_ENTRIES, 64, counter-table depth; power of two, 4..1024; IDX = log2(BHT_ENTRIES)
CTR_BITS, 2, saturating counter width, 1..4
GSHARE_EN, 0, 1 = index is PC bits XOR global history; 0 = PC bits only
GHR_BITS, 6, global history length; must be <= IDX
STAT_BITS, 32, width of statistics counters

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
pred_req  input  1  fetch lookup request
pred_pc  input  XLEN  fetch PC
pred_valid  output  1  lookup result valid, 1 cycle after pred_req
pred_taken  output  1  predicted direction
res_valid  input  1  branch resolving in execute this cycle
res_pc  input  XLEN  PC of resolving branch
res_funct3  input  3  branch funct3
res_rs1  input  XLEN  operand 1
res_rs2  input  XLEN  operand 2
res_pred_taken  input  1  prediction carried down the pipe with this branch
res_done  output  1  resolution result valid, 1 cycle after res_valid
res_taken  output  1  actual direction
res_mispredict  output  1  res_taken != carried prediction
res_illegal  output  1  funct3 was 010 or 011
stat_branches  output  STAT_BITS  legal resolved branches
stat_mispredicts  output  STAT_BITS  mispredicted legal branches

Behaviour:
- Reset (async, rst_n low):
  - All counters = weakly not-taken, i.e. value 2^(CTR_BITS-1)-1 (01 for 2 bits; 0 when CTR_BITS = 1).
  - GHR = 0; stats = 0.
  - All outputs 0. pred_valid and res_done stay 0 until the first request after rst_n rises.
- Index computation:
  - idx(pc) = pc[IDX+1:2] when GSHARE_EN = 0.
  - When GSHARE_EN = 1, GHR is zero-extended to IDX bits and XORed into the low bits of pc[IDX+1:2].
- Predict path:
  - On clk with pred_req = 1, register pred_valid = 1 and pred_taken = MSB of counter[idx(pred_pc)].
  - With pred_req = 0, register pred_valid = 0 and hold pred_taken.
  - Latency is exactly 1 cycle; a new request is accepted every cycle.
- Compare, per funct3:
  - 000 EQ taken if rs1 == rs2.
  - 001 NE taken if rs1 != rs2.
  - 100 LT taken if signed rs1 < rs2.
  - 101 GE taken if signed rs1 >= rs2.
  - 110 LTU taken if unsigned rs1 < rs2.
  - 111 GEU taken if unsigned rs1 >= rs2.
  - 010/011 are illegal.
- Resolve path, registered, 1 cycle latency:
  - res_done = res_valid. res_taken = compare result. res_mispredict = res_taken XOR res_pred_taken.
  - res_illegal = 1 for funct3 010/011; in that case force res_taken = 0 and res_mispredict = 0, and do not update the table, GHR or stats.
  - With res_valid = 0, res_done = 0 and the other resolve outputs hold.
- Training, same edge as the resolve registers, legal branches only:
  - counter[idx(res_pc)] increments if taken, decrements if not; saturates at 0 and 2^CTR_BITS-1.
  - Index uses the GHR value before this update.
  - GHR <= {GHR[GHR_BITS-2:0], res_taken}.
  - stat_branches++ and, on mispredict, stat_mispredicts++. Both saturate at all-ones (no wrap).
- Simultaneous predict and resolve to the same index: prediction reads the pre-update counter (read-before-write). With GSHARE_EN = 1, the prediction likewise uses the pre-update GHR.
- Reset asserted mid-operation clears everything immediately; pipelined results are discarded, not completed.

Test Plan:
- Reset, then pred_req with pred_pc = 0x100 -> pred_valid = 1, pred_taken = 0 next cycle; stats = 0.
- Compare table: rs1 = 0xFFFFFFFF, rs2 = 1.
  - funct3 100 -> res_taken = 1; 110 -> 0; 101 -> 0; 111 -> 1.
  - rs1 = rs2 = 5: 000 -> 1, 001 -> 0.
- Saturation, pc = 0x40, 2-bit counters:
  - 3 taken resolves -> counter 11, predict taken.
  - 4th taken -> stays 11.
  - 2 not-taken -> 01, predict not-taken.
- Mispredict: res_pred_taken = 1, funct3 000, rs1 = 1, rs2 = 2 -> res_taken = 0, res_mispredict = 1, stat_mispredicts = 1, stat_branches = 1.
- Illegal funct3 011 with res_valid -> res_illegal = 1, res_taken = 0, counter/GHR/stats unchanged.
- Same-cycle predict + resolve-taken on pc = 0x80 from reset -> pred_taken = 0. Repeat next cycle -> 1 (counter now 10).
- GSHARE_EN = 1, GHR_BITS = 2: resolve taken twice at pc = 0x0 -> GHR = 11; predict pc = 0xC uses idx 3 XOR 3 = 0.

Source files
------------

// File: rtl/branch_resolve_predict.sv
// Branch resolve + direction predictor: evaluates RV32I branch compares, trains a
// table of saturating counters (optionally gshare-indexed) and keeps mispredict stats.
module branch_resolve_predict #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CTR_BITS    = 2,
    parameter int GSHARE_EN   = 0,
    parameter int GHR_BITS    = 6,
    parameter int STAT_BITS   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pred_req,
    input  logic [XLEN-1:0]      pred_pc,
    output logic                 pred_valid,
    output logic                 pred_taken,
    input  logic                 res_valid,
    input  logic [XLEN-1:0]      res_pc,
    input  logic [2:0]           res_funct3,
    input  logic [XLEN-1:0]      res_rs1,
    input  logic [XLEN-1:0]      res_rs2,
    input  logic                 res_pred_taken,
    output logic                 res_done,
    output logic                 res_taken,
    output logic                 res_mispredict,
    output logic                 res_illegal,
    output logic [STAT_BITS-1:0] stat_branches,
    output logic [STAT_BITS-1:0] stat_mispredicts
);

    localparam int IDX = $clog2(BHT_ENTRIES);
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

    logic [CTR_BITS-1:0] bht [BHT_ENTRIES];
    logic [GHR_BITS-1:0] ghr;
    logic [IDX-1:0]      pred_idx;
    logic [IDX-1:0]      res_idx;
    logic                cmp_taken;
    logic                cmp_illegal;
    logic                mispredict;
    logic [GHR_BITS:0]   ghr_shift;

    function automatic logic [IDX-1:0] index_of(input logic [XLEN-1:0] pc,
                                                input logic [GHR_BITS-1:0] hist);
        logic [IDX-1:0] i;
        i = pc[IDX+1:2];
        if (GSHARE_EN != 0) i = i ^ IDX'(hist);
        return i;
    endfunction

    // Both indices use the pre-update GHR, so a same-edge predict reads old state.
    assign pred_idx   = index_of(pred_pc, ghr);
    assign res_idx    = index_of(res_pc, ghr);
    assign mispredict = cmp_taken ^ res_pred_taken;
    assign ghr_shift  = {ghr, cmp_taken};

    always_comb begin
        cmp_taken   = 1'b0;
        cmp_illegal = 1'b0;
        case (res_funct3)
            3'b000:  cmp_taken = (res_rs1 == res_rs2);
            3'b001:  cmp_taken = (res_rs1 != res_rs2);
            3'b100:  cmp_taken = ($signed(res_rs1) <  $signed(res_rs2));
            3'b101:  cmp_taken = ($signed(res_rs1) >= $signed(res_rs2));
            3'b110:  cmp_taken = (res_rs1 <  res_rs2);
            3'b111:  cmp_taken = (res_rs1 >= res_rs2);
            default: cmp_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BHT_ENTRIES; i++) bht[i] <= CTR_INIT;
            ghr              <= '0;
            pred_valid       <= 1'b0;
            pred_taken       <= 1'b0;
            res_done         <= 1'b0;
            res_taken        <= 1'b0;
            res_mispredict   <= 1'b0;
            res_illegal      <= 1'b0;
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            pred_valid <= pred_req;
            if (pred_req) pred_taken <= bht[pred_idx][CTR_BITS-1];

            res_done <= res_valid;
            if (res_valid) begin
                res_illegal <= cmp_illegal;
                if (cmp_illegal) begin
                    res_taken      <= 1'b0;
                    res_mispredict <= 1'b0;
                end else begin
                    res_taken      <= cmp_taken;
                    res_mispredict <= mispredict;
                    if (cmp_taken && bht[res_idx] != CTR_MAX)
                        bht[res_idx] <= bht[res_idx] + 1'b1;
                    else if (!cmp_taken && bht[res_idx] != '0)
                        bht[res_idx] <= bht[res_idx] - 1'b1;
                    ghr <= ghr_shift[GHR_BITS-1:0];
                    if (stat_branches != '1)
                        stat_branches <= stat_branches + STAT_BITS'(1);
                    if (mispredict && stat_mispredicts != '1)
                        stat_mispredicts <= stat_mispredicts + STAT_BITS'(1);
                end
            end
        end
    end

    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc[1:0], pred_pc[XLEN-1:IDX+2],
                              res_pc[1:0], res_pc[XLEN-1:IDX+2]};

endmodule

// File: tb/tb_branch_resolve_predict.sv
// Randomized + directed bench: a PC-indexed instance and a 2-bit gshare instance
// share stimulus and are compared each cycle against a behavioural model.
module tb_branch_resolve_predict;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pred_req = 1'b0;
    logic [31:0] pred_pc = '0;
    logic        res_valid = 1'b0;
    logic [31:0] res_pc = '0;
    logic [2:0]  res_funct3 = '0;
    logic [31:0] res_rs1 = '0;
    logic [31:0] res_rs2 = '0;
    logic        res_pred_taken = 1'b0;

    logic        pv [2];
    logic        pt [2];
    logic        rd [2];
    logic        rt [2];
    logic        rm [2];
    logic        ri [2];
    logic [31:0] sb [2];
    logic [31:0] sm [2];

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    branch_resolve_predict #(.GSHARE_EN(0)) u_pc (
        .clk(clk), .rst_n(rst_n), .pred_req(pred_req), .pred_pc(pred_pc),
        .pred_valid(pv[0]), .pred_taken(pt[0]), .res_valid(res_valid), .res_pc(res_pc),
        .res_funct3(res_funct3), .res_rs1(res_rs1), .res_rs2(res_rs2),
        .res_pred_taken(res_pred_taken), .res_done(rd[0]), .res_taken(rt[0]),
        .res_mispredict(rm[0]), .res_illegal(ri[0]),
        .stat_branches(sb[0]), .stat_mispredicts(sm[0]));

    branch_resolve_predict #(.GSHARE_EN(1), .GHR_BITS(2)) u_gs (
        .clk(clk), .rst_n(rst_n), .pred_req(pred_req), .pred_pc(pred_pc),
        .pred_valid(pv[1]), .pred_taken(pt[1]), .res_valid(res_valid), .res_pc(res_pc),
        .res_funct3(res_funct3), .res_rs1(res_rs1), .res_rs2(res_rs2),
        .res_pred_taken(res_pred_taken), .res_done(rd[1]), .res_taken(rt[1]),
        .res_mispredict(rm[1]), .res_illegal(ri[1]),
        .stat_branches(sb[1]), .stat_mispredicts(sm[1]));

    // Model state: counters 0..3 per entry, history as an integer, expected outputs.
    int unsigned m_ctr [2][64];
    int unsigned m_ghr [2];
    int unsigned m_sb [2];
    int unsigned m_sm [2];
    bit e_pv [2], e_pt [2], e_rd [2], e_rt [2], e_rm [2], e_ri [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned m_idx(input int g, input logic [31:0] pc);
        int unsigned i;
        i = (pc >> 2) % 64;
        if (g == 1) i = i ^ m_ghr[1];
        return i;
    endfunction

    function automatic bit ref_taken(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
        int sa, sb2;
        longint ua, ub;
        sa = int'(a); sb2 = int'(b);
        ua = longint'({32'b0, a}); ub = longint'({32'b0, b});
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb2;
            3'd5: return sa >= sb2;
            3'd6: return ua < ub;
            3'd7: return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 64; i++) m_ctr[g][i] = 1;
            m_ghr[g] = 0; m_sb[g] = 0; m_sm[g] = 0;
            e_pv[g] = 0; e_pt[g] = 0; e_rd[g] = 0; e_rt[g] = 0; e_rm[g] = 0; e_ri[g] = 0;
        end
    endtask

    task automatic check_all(input string when);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("%s pred_valid[%0d]", when, g), 32'(pv[g]), 32'(e_pv[g]));
            check($sformatf("%s pred_taken[%0d]", when, g), 32'(pt[g]), 32'(e_pt[g]));
            check($sformatf("%s res_done[%0d]", when, g), 32'(rd[g]), 32'(e_rd[g]));
            check($sformatf("%s res_taken[%0d]", when, g), 32'(rt[g]), 32'(e_rt[g]));
            check($sformatf("%s res_mispredict[%0d]", when, g), 32'(rm[g]), 32'(e_rm[g]));
            check($sformatf("%s res_illegal[%0d]", when, g), 32'(ri[g]), 32'(e_ri[g]));
            check($sformatf("%s stat_branches[%0d]", when, g), sb[g], m_sb[g]);
            check($sformatf("%s stat_mispredicts[%0d]", when, g), sm[g], m_sm[g]);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pred_req = 1'b0; res_valid = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic cycle(input bit preq, input logic [31:0] ppc, input bit rv,
                         input logic [31:0] rpc, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input bit rpt);
        bit t;
        int unsigned i;
        pred_req = preq; pred_pc = ppc; res_valid = rv; res_pc = rpc;
        res_funct3 = f3; res_rs1 = a; res_rs2 = b; res_pred_taken = rpt;
        for (int g = 0; g < 2; g++) begin
            e_pv[g] = preq;
            if (preq) e_pt[g] = m_ctr[g][m_idx(g, ppc)] >= 2;
            e_rd[g] = rv;
            if (rv) begin
                if (f3 == 3'd2 || f3 == 3'd3) begin
                    e_ri[g] = 1; e_rt[g] = 0; e_rm[g] = 0;
                end else begin
                    t = ref_taken(f3, a, b);
                    e_ri[g] = 0; e_rt[g] = t; e_rm[g] = t ^ rpt;
                    i = m_idx(g, rpc);
                    if (t && m_ctr[g][i] < 3) m_ctr[g][i]++;
                    if (!t && m_ctr[g][i] > 0) m_ctr[g][i]--;
                    m_ghr[g] = ((m_ghr[g] << 1) | 32'(t)) % (g == 1 ? 4 : 64);
                    m_sb[g]++;
                    if (t != rpt) m_sm[g]++;
                end
            end
        end
        @(posedge clk);
        #1;
        check_all("cyc");
    endtask

    initial begin
        logic [31:0] a, b;
        do_reset();

        // First lookup after reset: weakly not-taken.
        cycle(1, 32'h100, 0, 0, 0, 0, 0, 0);
        check("first pred", 32'(pt[0]), 32'd0);

        // Compare table.
        cycle(0, 0, 1, 32'h200, 3'd4, 32'hFFFF_FFFF, 32'd1, 0);
        check("blt -1<1", 32'(rt[0]), 32'd1);
        cycle(0, 0, 1, 32'h204, 3'd6, 32'hFFFF_FFFF, 32'd1, 0);
        check("bltu", 32'(rt[0]), 32'd0);
        cycle(0, 0, 1, 32'h208, 3'd5, 32'hFFFF_FFFF, 32'd1, 0);
        check("bge", 32'(rt[0]), 32'd0);
        cycle(0, 0, 1, 32'h20C, 3'd7, 32'hFFFF_FFFF, 32'd1, 0);
        check("bgeu", 32'(rt[0]), 32'd1);
        cycle(0, 0, 1, 32'h210, 3'd0, 32'd5, 32'd5, 0);
        check("beq", 32'(rt[0]), 32'd1);
        cycle(0, 0, 1, 32'h214, 3'd1, 32'd5, 32'd5, 0);
        check("bne", 32'(rt[0]), 32'd0);

        // Saturation at pc 0x40.
        do_reset();
        repeat (4) cycle(0, 0, 1, 32'h40, 3'd0, 32'd7, 32'd7, 0);
        cycle(1, 32'h40, 0, 0, 0, 0, 0, 0);
        check("sat taken", 32'(pt[0]), 32'd1);
        repeat (2) cycle(0, 0, 1, 32'h40, 3'd1, 32'd7, 32'd7, 0);
        cycle(1, 32'h40, 0, 0, 0, 0, 0, 0);
        check("sat back nt", 32'(pt[0]), 32'd0);

        // Mispredict then illegal funct3 (no state change).
        do_reset();
        cycle(0, 0, 1, 32'h60, 3'd0, 32'd1, 32'd2, 1);
        check("misp flag", 32'(rm[0]), 32'd1);
        check("misp stat", sm[0], 32'd1);
        cycle(0, 0, 1, 32'h60, 3'd3, 32'd1, 32'd1, 1);
        check("illegal", 32'(ri[0]), 32'd1);
        check("illegal stat", sb[0], 32'd1);

        // Read-before-write on a same-cycle predict + resolve.
        do_reset();
        cycle(1, 32'h80, 1, 32'h80, 3'd0, 32'd3, 32'd3, 0);
        check("rbw old", 32'(pt[0]), 32'd0);
        cycle(1, 32'h80, 1, 32'h80, 3'd0, 32'd3, 32'd3, 0);
        check("rbw new", 32'(pt[0]), 32'd1);

        // Gshare: two taken at pc 0 give GHR=11, so pc 0xC maps to entry 0.
        do_reset();
        repeat (2) cycle(0, 0, 1, 32'h0, 3'd0, 32'd9, 32'd9, 0);
        cycle(1, 32'hC, 0, 0, 0, 0, 0, 0);
        check("gshare pred", 32'(pt[1]), 32'd1);
        check("pc-only pred", 32'(pt[0]), 32'd0);

        // Mid-operation reset discards in-flight results.
        cycle(1, 32'h40, 1, 32'h40, 3'd0, 32'd1, 32'd1, 1);
        cycle(1, 32'h40, 1, 32'h40, 3'd0, 32'd1, 32'd1, 1);
        do_reset();

        // Randomized traffic over a small PC window to force aliasing.
        for (int n = 0; n < 3000; n++) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 3) == 0) a = a ^ 32'h8000_0000;
            cycle(1'($urandom_range(0, 1)), {$urandom_range(0, 255), 2'b0} ^ 32'hABC0_0000,
                  1'($urandom_range(0, 3) != 0), {$urandom_range(0, 255), 2'b0},
                  3'($urandom_range(0, 7)), a, b, 1'($urandom_range(0, 1)));
            if (n == 1500) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
